fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM address and enable.
- Captures the 32-bit little-endian word the ROM returns into a registered IF/ID slot, handed to decode with a valid/ready handshake.
- Accepts branch/jump redirects from later stages, flushes the slot on redirect, and enters a sticky fault state on a misaligned or out-of-range PC.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/if_id_reg.sv | 45 ++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pkg                                                          |
// | Shared types and constants for the instruction-fetch stage.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package fetch_pkg;

  // Fetch controller states
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  // Size of one instruction word in bytes
  localparam int unsigned INSTR_BYTES = 4;

  // Low PC bits that must be zero for an aligned fetch
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_id_reg                                                          |
// | IF/ID pipeline slot with valid/ready handshake; supports load,     |
// | flush and hold, and clears itself once decode consumes the entry.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module if_id_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic        ready,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  // Flush beats load; with neither, a consumed entry drops its valid bit
  // while an unconsumed one holds all fields stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= 1'b0;
      instr    <= 32'd0;
      pc       <= 32'd0;
      pc_plus4 <= 32'd0;
    end else if (flush) begin
      valid    <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= instr_in;
      pc       <= pc_in;
      pc_plus4 <= pc_in + 32'(INSTR_BYTES);
    end else if (valid && ready) begin
      valid    <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit                                                         |
// | Instruction-fetch stage: owns the PC, drives the ROM, captures the |
// | returned word into the IF/ID slot, honours redirects and raises a  |
// | sticky fault on misaligned or out-of-range PCs.                    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  output logic        rom_en,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fault,
  output logic [31:0] fault_pc
);

  // Highest legal fetch address, and the address reported when fetch runs off the end
  localparam logic [31:0] LAST_PC = 32'(ROM_BYTES - INSTR_BYTES);
  localparam logic [31:0] END_PC  = 32'(ROM_BYTES);

  fetch_state_e state;
  fetch_state_e state_next;
  logic [31:0]  pc;
  logic [31:0]  pc_next;
  logic [31:0]  fault_pc_next;
  logic         slot_load;
  logic         slot_flush;
  logic         slot_free;
  logic         target_bad;

  assign rom_addr   = pc;
  assign rom_en     = (state == ST_RUN);
  assign fault      = (state == ST_FAULT);
  assign slot_free  = !id_valid || id_ready;
  assign target_bad = ((redirect_target[1:0] & ALIGN_MASK) != 2'b00) ||
                      (redirect_target > LAST_PC);

  // Next-state, next-PC and slot control: redirect first, then fetch, else stall
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    fault_pc_next = fault_pc;
    slot_load     = 1'b0;
    slot_flush    = 1'b0;
    case (state)
      ST_BOOT: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          slot_flush = 1'b1;
          if (target_bad) begin
            state_next    = ST_FAULT;
            fault_pc_next = redirect_target;
          end else begin
            pc_next = redirect_target;
          end
        end else if (slot_free) begin
          slot_load = 1'b1;
          if (pc == LAST_PC) begin
            // Deliver the final word, then stop: the next PC would be outside the ROM
            state_next    = ST_FAULT;
            fault_pc_next = END_PC;
          end else begin
            pc_next = pc + 32'(INSTR_BYTES);
          end
        end
      end
      ST_FAULT: begin
        // Sticky until reset; the slot drains on its own via the handshake
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  // State, PC and fault-address registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_BOOT;
      pc       <= RESET_PC;
      fault_pc <= 32'd0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      fault_pc <= fault_pc_next;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (slot_load),
    .flush    (slot_flush),
    .ready    (id_ready),
    .instr_in (rom_data),
    .pc_in    (pc),
    .valid    (id_valid),
    .instr    (id_instr),
    .pc       (id_pc),
    .pc_plus4 (id_pc_plus4)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_unit                                                      |
// | Directed scenarios plus randomized traffic against a cycle-level   |
// | behavioural model of the fetch stage.                              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rom_addr;
  logic        rom_en;
  logic [31:0] rom_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        id_ready = 1'b1;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fault;
  logic [31:0] fault_pc;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rom_mem [0:255];

  // Reference model state (mode: 0 boot, 1 run, 2 fault)
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_idpc;
  logic [31:0] m_idpc4;
  logic [31:0] m_fault_pc;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .rom_addr        (rom_addr),
    .rom_en          (rom_en),
    .rom_data        (rom_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_ready        (id_ready),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4),
    .fault           (fault),
    .fault_pc        (fault_pc)
  );

  always #5 clk = ~clk;

  // Combinational ROM
  always_comb begin
    rom_data = 32'hDEAD_BEEF;
    if (rom_addr < 32'd1024) rom_data = rom_mem[rom_addr[9:2]];
  end

  // Behavioural fetch model, advanced once per rising edge from pre-edge inputs
  task automatic model_step();
    if (reset) begin
      m_mode = 0; m_pc = 32'd0; m_valid = 1'b0; m_instr = 32'd0;
      m_idpc = 32'd0; m_idpc4 = 32'd0; m_fault_pc = 32'd0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (redirect_valid) begin
        m_valid = 1'b0;
        if ((redirect_target % 4) != 0 || redirect_target > 32'd1020) begin
          m_mode = 2; m_fault_pc = redirect_target;
        end else begin
          m_pc = redirect_target;
        end
      end else if (!m_valid || id_ready) begin
        m_instr = rom_mem[m_pc / 4]; m_idpc = m_pc; m_idpc4 = m_pc + 4; m_valid = 1'b1;
        if (m_pc == 32'd1020) begin
          m_mode = 2; m_fault_pc = 32'd1024;
        end else begin
          m_pc = m_pc + 4;
        end
      end
    end else begin
      if (m_valid && id_ready) m_valid = 1'b0;
    end
  endtask

  // One clock: model follows the edge, outputs are then sampled 1 time unit later
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Reset, run BOOT, then load pc 0 and pc 4 so the slot holds pc 4
  task automatic boot_to_pc4();
    reset = 1'b1; redirect_valid = 1'b0; id_ready = 1'b1;
    cyc();
    reset = 1'b0;
    cyc(); cyc(); cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0;
    cyc(); cyc();
    vectors++;
    if (id_valid !== 1'b0 || id_instr !== 32'd0 || id_pc !== 32'd0 || id_pc_plus4 !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_slot got v=%0b i=%h pc=%h p4=%h want all zero", id_valid, id_instr, id_pc, id_pc_plus4);
    end
    vectors++;
    if (fault !== 1'b0 || fault_pc !== 32'd0 || rom_en !== 1'b0 || rom_addr !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl got fault=%0b fpc=%h en=%0b addr=%h want 0 0 0 0", fault, fault_pc, rom_en, rom_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] words [0:3];
    words[0] = 32'h0000_0000; words[1] = 32'h9912_7254;
    words[2] = 32'h1234_5678; words[3] = 32'h8911_7843;
    cyc();
    vectors++;
    if (id_valid !== 1'b0 || rom_en !== 1'b1) begin
      miscompares++;
      $display("FAIL boot_exit got v=%0b en=%0b want v=0 en=1", id_valid, rom_en);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      vectors++;
      if (id_valid !== 1'b1 || id_instr !== words[i] || id_pc !== 32'(4*i) || id_pc_plus4 !== 32'(4*i+4)) begin
        miscompares++;
        $display("FAIL stream_%0d got v=%0b i=%h pc=%h p4=%h want 1 %h %h %h", i, id_valid, id_instr, id_pc,
                 id_pc_plus4, words[i], 32'(4*i), 32'(4*i+4));
      end
    end
  endtask

  task automatic test_stall();
    boot_to_pc4();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vectors++;
      if (id_valid !== 1'b1 || id_instr !== 32'h9912_7254 || id_pc !== 32'd4 || rom_addr !== 32'd8) begin
        miscompares++;
        $display("FAIL stall_%0d got v=%0b i=%h pc=%h addr=%h want 1 99127254 4 8", i, id_valid, id_instr, id_pc, rom_addr);
      end
    end
    id_ready = 1'b1;
    cyc();
    vectors++;
    if (id_valid !== 1'b1 || id_instr !== 32'h1234_5678 || id_pc !== 32'd8) begin
      miscompares++;
      $display("FAIL stall_release got v=%0b i=%h pc=%h want 1 12345678 8", id_valid, id_instr, id_pc);
    end
  endtask

  task automatic test_redirect();
    boot_to_pc4();
    redirect_valid = 1'b1; redirect_target = 32'd16;
    cyc();
    redirect_valid = 1'b0;
    vectors++;
    if (id_valid !== 1'b0 || rom_addr !== 32'd16 || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_flush got v=%0b addr=%h fault=%0b want 0 10 0", id_valid, rom_addr, fault);
    end
    cyc();
    vectors++;
    if (id_valid !== 1'b1 || id_instr !== 32'h1241_8549 || id_pc !== 32'd16 || id_pc_plus4 !== 32'd20) begin
      miscompares++;
      $display("FAIL redirect_fetch got v=%0b i=%h pc=%h p4=%h want 1 12418549 10 14", id_valid, id_instr, id_pc, id_pc_plus4);
    end
  endtask

  task automatic test_misaligned();
    boot_to_pc4();
    id_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h6;
    cyc();
    vectors++;
    if (fault !== 1'b1 || fault_pc !== 32'h6 || rom_en !== 1'b0 || id_valid !== 1'b0 || rom_addr !== 32'd8) begin
      miscompares++;
      $display("FAIL misalign_fault got f=%0b fpc=%h en=%0b v=%0b addr=%h want 1 6 0 0 8", fault, fault_pc, rom_en,
               id_valid, rom_addr);
    end
    redirect_target = 32'd16; id_ready = 1'b1;
    cyc(); cyc();
    redirect_valid = 1'b0;
    vectors++;
    if (fault !== 1'b1 || fault_pc !== 32'h6 || rom_addr !== 32'd8 || id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_sticky got f=%0b fpc=%h addr=%h v=%0b want 1 6 8 0", fault, fault_pc, rom_addr, id_valid);
    end
  endtask

  task automatic test_end_of_rom();
    boot_to_pc4();
    redirect_valid = 1'b1; redirect_target = 32'd1020;
    cyc();
    redirect_valid = 1'b0; id_ready = 1'b0;
    cyc();
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'd1020 || id_instr !== rom_mem[255] || id_pc_plus4 !== 32'd1024) begin
      miscompares++;
      $display("FAIL eor_deliver got v=%0b pc=%h i=%h p4=%h want 1 3fc %h 400", id_valid, id_pc, id_instr, id_pc_plus4, rom_mem[255]);
    end
    vectors++;
    if (fault !== 1'b1 || fault_pc !== 32'd1024 || rom_en !== 1'b0) begin
      miscompares++;
      $display("FAIL eor_fault got f=%0b fpc=%h en=%0b want 1 400 0", fault, fault_pc, rom_en);
    end
    cyc();
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'd1020) begin
      miscompares++;
      $display("FAIL eor_pending got v=%0b pc=%h want 1 3fc", id_valid, id_pc);
    end
    id_ready = 1'b1;
    cyc(); cyc();
    vectors++;
    if (id_valid !== 1'b0 || fault !== 1'b1) begin
      miscompares++;
      $display("FAIL eor_drain got v=%0b f=%0b want 0 1", id_valid, fault);
    end
  endtask

  task automatic test_reset_mid_stall();
    boot_to_pc4();
    id_ready = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0; id_ready = 1'b1;
    vectors++;
    if (id_valid !== 1'b0 || fault !== 1'b0 || rom_addr !== 32'd0 || rom_en !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset got v=%0b f=%0b addr=%h en=%0b want 0 0 0 0", id_valid, fault, rom_addr, rom_en);
    end
    cyc(); cyc();
    vectors++;
    if (id_valid !== 1'b1 || id_instr !== 32'd0 || id_pc !== 32'd0) begin
      miscompares++;
      $display("FAIL midreset_resume got v=%0b i=%h pc=%h want 1 0 0", id_valid, id_instr, id_pc);
    end
  endtask

  task automatic test_random();
    int sel;
    reset = 1'b1; redirect_valid = 1'b0; id_ready = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      cyc();
      vectors++;
      if (id_valid !== m_valid || (m_valid && (id_instr !== m_instr || id_pc !== m_idpc || id_pc_plus4 !== m_idpc4))) begin
        miscompares++;
        $display("FAIL rnd_slot cyc %0d got v=%0b i=%h pc=%h p4=%h want v=%0b i=%h pc=%h p4=%h", n, id_valid, id_instr,
                 id_pc, id_pc_plus4, m_valid, m_instr, m_idpc, m_idpc4);
      end
      vectors++;
      if (rom_addr !== m_pc || rom_en !== (m_mode == 1) || fault !== (m_mode == 2) || fault_pc !== m_fault_pc) begin
        miscompares++;
        $display("FAIL rnd_ctrl cyc %0d got addr=%h en=%0b f=%0b fpc=%h want addr=%h en=%0b f=%0b fpc=%h", n, rom_addr,
                 rom_en, fault, fault_pc, m_pc, (m_mode == 1), (m_mode == 2), m_fault_pc);
      end
      reset    = ($urandom_range(0, 59) == 0);
      id_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 9) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 7)       redirect_target = 32'($urandom_range(0, 255)) * 4;
      else if (sel == 7) redirect_target = 32'($urandom_range(0, 1023)) | 32'd1;
      else if (sel == 8) redirect_target = 32'd1020;
      else               redirect_target = $urandom;
    end
    reset = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
    rom_mem[0] = 32'h0000_0000;
    rom_mem[1] = 32'h9912_7254;
    rom_mem[2] = 32'h1234_5678;
    rom_mem[3] = 32'h8911_7843;
    rom_mem[4] = 32'h1241_8549;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misaligned();
    test_end_of_rom();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
